// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SUB_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// Purely combinational 1-bit full subtractor: d = a - b - borrow_in.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic d,
  output logic borrow_out
);

  assign d          = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell plus a registered
// borrow, walking the operands LSB-first with valid/ready on both sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > SUB_WIDTH_MAX) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be in 2..32");
  end

  sub_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             borrow_r;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_borrow;

  full_subtractor_cell u_cell (
    .a          (a_sh[0]),
    .b          (b_sh[0]),
    .borrow_in  (borrow_r),
    .d          (cell_d),
    .borrow_out (cell_borrow)
  );

  // State register; reset drops any in-flight operation back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: accept in IDLE, WIDTH shift cycles, hold result in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Operand/result shifters, borrow flop and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      d_sh     <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            d_sh     <= '0;
            borrow_r <= 1'b0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          d_sh     <= {cell_d, d_sh[WIDTH-1:1]};
          borrow_r <= cell_borrow;
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          // Saturate on the last bit so the counter never wraps.
          if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs are decoded from state and registered values only.
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign diff       = (state == DONE) ? d_sh : '0;
  assign borrow_out = (state == DONE) ? borrow_r : 1'b0;

endmodule
